// File: rtl/rv32i_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_bus_pkg
// Description : Shared types and sizes for the host load/debug bus responder.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32i_bus_pkg;

    localparam int ADDRESS_LENGTH_DEF = 11;
    localparam int IMEM_WORDS         = 2 ** ADDRESS_LENGTH_DEF;
    localparam int DMEM_WORDS         = 2 ** ADDRESS_LENGTH_DEF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_ACCESS  = 3'd2,
        ST_RDWAIT  = 3'd3,
        ST_RELEASE = 3'd4
    } load_state_t;

    typedef enum logic {
        TGT_IMEM = 1'b0,
        TGT_DMEM = 1'b1
    } target_t;

endpackage
`default_nettype wire

// File: rtl/apb_load_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : apb_load_responder_if
// Description : Host load/debug bus; master = host pins, slave = responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface apb_load_responder_if #(
    parameter int DATA_LENGTH = 32
);
    logic [31:0]            addr_in;
    logic [DATA_LENGTH-1:0] data_in;
    logic                   pselect;
    logic                   pwrite;
    logic                   pready;
    logic [DATA_LENGTH-1:0] data_out;
    logic                   xfer_done;
    logic                   xfer_err;

    modport master (
        output addr_in, data_in, pselect, pwrite, pready,
        input  data_out, xfer_done, xfer_err
    );

    modport slave (
        input  addr_in, data_in, pselect, pwrite, pready,
        output data_out, xfer_done, xfer_err
    );
endinterface
`default_nettype wire

// File: rtl/apb_addr_decode.sv
`default_nettype none
// ============================================================================
// Module      : apb_addr_decode
// Description : Legality check and word-index decode of a captured transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_addr_decode
    import rv32i_bus_pkg::*;
#(
    parameter int ADDRESS_LENGTH = 11
) (
    input  logic [31:0]               addr_i,
    input  logic                      pwrite_i,
    input  target_t                   target_i,
    output logic                      legal_o,
    output logic                      to_imem_o,
    output logic [ADDRESS_LENGTH-1:0] word_idx_o
);

    always_comb begin
        legal_o    = 1'b0;
        to_imem_o  = 1'b0;
        word_idx_o = '0;
        if (pwrite_i && (target_i == TGT_IMEM)) begin
            // imem is loaded by word index, not byte address
            to_imem_o  = 1'b1;
            legal_o    = (addr_i[31:ADDRESS_LENGTH] == '0);
            word_idx_o = addr_i[ADDRESS_LENGTH-1:0];
        end else begin
            // Reads always go to dmem; a read while loading imem is rejected
            legal_o    = (addr_i[1:0] == 2'b00)
                      && (addr_i[31:ADDRESS_LENGTH+2] == '0)
                      && !(!pwrite_i && (target_i == TGT_IMEM));
            word_idx_o = addr_i[ADDRESS_LENGTH+1:2];
        end
    end

endmodule
`default_nettype wire

// File: rtl/apb_load_responder.sv
`default_nettype none
// ============================================================================
// Module      : apb_load_responder
// Description : Turns each host bus transfer into one imem/dmem access.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_load_responder
    import rv32i_bus_pkg::*;
#(
    parameter int DATA_LENGTH    = 32,
    parameter int ADDRESS_LENGTH = 11
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      core_select,
    input  logic                      instruction_load_start,
    apb_load_responder_if.slave       bus,
    output logic                      imem_we,
    output logic [ADDRESS_LENGTH-1:0] imem_addr,
    output logic [DATA_LENGTH-1:0]    imem_wdata,
    output logic                      dmem_we,
    output logic                      dmem_re,
    output logic [ADDRESS_LENGTH-1:0] dmem_addr,
    output logic [DATA_LENGTH-1:0]    dmem_wdata,
    input  logic [DATA_LENGTH-1:0]    dmem_rdata,
    output logic                      core_en,
    output logic [ADDRESS_LENGTH:0]   load_count
);

    localparam logic [ADDRESS_LENGTH:0] LOAD_MAX = {1'b1, {ADDRESS_LENGTH{1'b0}}};

    load_state_t               state_q;
    logic [31:0]               addr_q;
    logic [DATA_LENGTH-1:0]    wdata_q;
    logic                      pwrite_q;
    target_t                   target_q;
    logic                      rd_q;
    logic                      imem_we_q;
    logic [ADDRESS_LENGTH-1:0] imem_addr_q;
    logic [DATA_LENGTH-1:0]    imem_wdata_q;
    logic                      dmem_we_q;
    logic                      dmem_re_q;
    logic [ADDRESS_LENGTH-1:0] dmem_addr_q;
    logic [DATA_LENGTH-1:0]    dmem_wdata_q;
    logic [DATA_LENGTH-1:0]    data_out_q;
    logic                      done_q;
    logic                      err_q;
    logic                      core_en_q;
    logic [ADDRESS_LENGTH:0]   load_count_q;

    logic                      w_legal;
    logic                      w_to_imem;
    logic [ADDRESS_LENGTH-1:0] w_idx;
    logic                      w_req;

    assign w_req = bus.pselect & bus.pready;

    apb_addr_decode #(
        .ADDRESS_LENGTH (ADDRESS_LENGTH)
    ) u_decode (
        .addr_i     (addr_q),
        .pwrite_i   (pwrite_q),
        .target_i   (target_q),
        .legal_o    (w_legal),
        .to_imem_o  (w_to_imem),
        .word_idx_o (w_idx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            pwrite_q     <= 1'b0;
            target_q     <= TGT_DMEM;
            rd_q         <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            dmem_we_q    <= 1'b0;
            dmem_re_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            data_out_q   <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            core_en_q    <= 1'b0;
            load_count_q <= '0;
        end else begin
            imem_we_q <= 1'b0;
            dmem_we_q <= 1'b0;
            dmem_re_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            core_en_q <= core_select & ~instruction_load_start
                       & (state_q == ST_IDLE) & ~w_req;

            case (state_q)
                ST_IDLE: begin
                    if (w_req) begin
                        addr_q   <= bus.addr_in;
                        wdata_q  <= bus.data_in;
                        pwrite_q <= bus.pwrite;
                        target_q <= instruction_load_start ? TGT_IMEM : TGT_DMEM;
                        state_q  <= ST_CAPTURE;
                    end
                end
                // Strobes are set on this edge so they are high during ACCESS
                ST_CAPTURE: begin
                    state_q <= ST_ACCESS;
                    rd_q    <= 1'b0;
                    if (!w_legal) begin
                        done_q <= 1'b1;
                        err_q  <= 1'b1;
                    end else if (w_to_imem) begin
                        imem_we_q    <= 1'b1;
                        imem_addr_q  <= w_idx;
                        imem_wdata_q <= wdata_q;
                        done_q       <= 1'b1;
                        if (load_count_q != LOAD_MAX) begin
                            load_count_q <= load_count_q + {{ADDRESS_LENGTH{1'b0}}, 1'b1};
                        end
                    end else begin
                        dmem_addr_q <= w_idx;
                        if (pwrite_q) begin
                            dmem_we_q    <= 1'b1;
                            dmem_wdata_q <= wdata_q;
                            done_q       <= 1'b1;
                        end else begin
                            dmem_re_q <= 1'b1;
                            rd_q      <= 1'b1;
                        end
                    end
                end
                ST_ACCESS: begin
                    state_q <= rd_q ? ST_RDWAIT : ST_RELEASE;
                end
                // Read completion is signalled together with the new data_out
                ST_RDWAIT: begin
                    data_out_q <= dmem_rdata;
                    done_q     <= 1'b1;
                    state_q    <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (!bus.pselect) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign imem_we       = imem_we_q;
    assign imem_addr     = imem_addr_q;
    assign imem_wdata    = imem_wdata_q;
    assign dmem_we       = dmem_we_q;
    assign dmem_re       = dmem_re_q;
    assign dmem_addr     = dmem_addr_q;
    assign dmem_wdata    = dmem_wdata_q;
    assign core_en       = core_en_q;
    assign load_count    = load_count_q;
    assign bus.data_out  = data_out_q;
    assign bus.xfer_done = done_q;
    assign bus.xfer_err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_load_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_load_responder
// Description : Directed self-checking bench for apb_load_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_load_responder;
    import rv32i_bus_pkg::*;

    localparam int DL = 32;
    localparam int AL = 11;

    logic          clk = 1'b0;
    logic          rst;
    logic          core_select;
    logic          instruction_load_start;
    logic          imem_we;
    logic [AL-1:0] imem_addr;
    logic [DL-1:0] imem_wdata;
    logic          dmem_we;
    logic          dmem_re;
    logic [AL-1:0] dmem_addr;
    logic [DL-1:0] dmem_wdata;
    logic [DL-1:0] dmem_rdata = '0;
    logic          core_en;
    logic [AL:0]   load_count;

    logic [DL-1:0] mem [0:DMEM_WORDS-1];

    int n_checks = 0;
    int n_fail   = 0;
    int n_imem = 0, n_dwe = 0, n_dre = 0, n_done = 0, n_err = 0, n_orphan = 0;

    apb_load_responder_if #(.DATA_LENGTH(DL)) bus_if ();

    apb_load_responder #(
        .DATA_LENGTH    (DL),
        .ADDRESS_LENGTH (AL)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .core_select            (core_select),
        .instruction_load_start (instruction_load_start),
        .bus                    (bus_if),
        .imem_we                (imem_we),
        .imem_addr              (imem_addr),
        .imem_wdata             (imem_wdata),
        .dmem_we                (dmem_we),
        .dmem_re                (dmem_re),
        .dmem_addr              (dmem_addr),
        .dmem_wdata             (dmem_wdata),
        .dmem_rdata             (dmem_rdata),
        .core_en                (core_en),
        .load_count             (load_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dmem_we) mem[dmem_addr] <= dmem_wdata;
        if (dmem_re) dmem_rdata <= mem[dmem_addr];
    end

    always @(posedge clk) begin
        if (imem_we) n_imem++;
        if (dmem_we) n_dwe++;
        if (dmem_re) n_dre++;
        if (bus_if.xfer_done) n_done++;
        if (bus_if.xfer_err) n_err++;
        if (bus_if.xfer_err && !bus_if.xfer_done) n_orphan++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        bus_if.pselect = 1'b0;
        bus_if.pready  = 1'b0;
    endtask

    task automatic start_req(input logic [31:0] a, input logic [31:0] d,
                             input logic wr, input logic ld);
        bus_if.addr_in         = a;
        bus_if.data_in         = d;
        bus_if.pwrite          = wr;
        instruction_load_start = ld;
        bus_if.pselect         = 1'b1;
        bus_if.pready          = 1'b1;
    endtask

    task automatic xfer(input logic [31:0] a, input logic [31:0] d,
                        input logic wr, input logic ld, input int hold);
        @(negedge clk);
        start_req(a, d, wr, ld);
        repeat (hold) @(negedge clk);
        bus_idle();
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int s_imem, s_dwe, s_dre, s_done, s_err, en_hi;
        rst = 1'b0;
        core_select = 1'b0;
        instruction_load_start = 1'b0;
        bus_if.addr_in = '0;
        bus_if.data_in = '0;
        bus_if.pwrite  = 1'b0;
        bus_idle();

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_core_en",    core_en, 0);
        check("rst_load_count", load_count, 0);
        check("rst_data_out",   bus_if.data_out, 0);
        check("rst_imem_we",    imem_we, 0);
        check("rst_done",       bus_if.xfer_done, 0);
        check("rst_imem_addr",  imem_addr, 0);
        check("rst_dmem_addr",  dmem_addr, 0);
        rst = 1'b1;
        @(negedge clk);

        // 1: single imem write
        s_imem = n_imem; s_err = n_err; s_done = n_done;
        xfer(32'h5, 32'h0050_0093, 1'b1, 1'b1, 4);
        check("t1_imem_pulses", n_imem - s_imem, 1);
        check("t1_imem_addr",   imem_addr, 5);
        check("t1_imem_wdata",  imem_wdata, 32'h0050_0093);
        check("t1_load_count",  load_count, 1);
        check("t1_err",         n_err - s_err, 0);
        check("t1_done",        n_done - s_done, 1);

        // 2: 20 sequential imem words, first with a long hold
        do_reset();
        s_imem = n_imem; s_dwe = n_dwe; s_dre = n_dre;
        for (int i = 0; i < 20; i++)
            xfer(i, 32'h1000 + i, 1'b1, 1'b1, (i == 0) ? 10 : 4);
        check("t2_imem_pulses", n_imem - s_imem, 20);
        check("t2_load_count",  load_count, 20);
        check("t2_imem_addr",   imem_addr, 19);
        check("t2_imem_wdata",  imem_wdata, 32'h1013);
        check("t2_dmem_strobes", (n_dwe - s_dwe) + (n_dre - s_dre), 0);

        // 3: dmem write then read-back with latency check
        s_dwe = n_dwe; s_dre = n_dre;
        xfer(32'h294, 32'hDEAD_BEEF, 1'b1, 1'b0, 4);
        check("t3_dwe_pulses", n_dwe - s_dwe, 1);
        check("t3_dmem_addr",  dmem_addr, 165);
        check("t3_dmem_wdata", dmem_wdata, 32'hDEAD_BEEF);
        s_done = n_done;
        @(negedge clk);
        start_req(32'h294, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        repeat (2) @(posedge clk);
        #1 check("t3_data_early", bus_if.data_out, 0);
        @(posedge clk);
        #1 check("t3_data_out", bus_if.data_out, 32'hDEAD_BEEF);
        check("t3_done_with_data", bus_if.xfer_done, 1);
        @(negedge clk);
        bus_idle();
        repeat (2) @(negedge clk);
        check("t3_rd_done_pulses", n_done - s_done, 1);
        check("t3_dre_pulses", n_dre - s_dre, 1);

        // 4: rejected transfers
        s_imem = n_imem; s_dwe = n_dwe; s_dre = n_dre; s_err = n_err; s_done = n_done;
        xfer(32'h802, 32'h11, 1'b1, 1'b1, 4);
        xfer(32'h2A1, 32'h22, 1'b1, 1'b0, 4);
        xfer(32'h10,  32'h0,  1'b0, 1'b1, 4);
        check("t4_no_strobes", (n_imem - s_imem) + (n_dwe - s_dwe) + (n_dre - s_dre), 0);
        check("t4_err_pulses",  n_err - s_err, 3);
        check("t4_done_pulses", n_done - s_done, 3);
        check("t4_err_without_done", n_orphan, 0);
        check("t4_load_count", load_count, 20);

        // 5: core_en gating
        @(negedge clk);
        core_select = 1'b1;
        instruction_load_start = 1'b0;
        @(posedge clk);
        #1 check("t5_core_en_on", core_en, 1);
        @(negedge clk);
        start_req(32'h40, 32'h55, 1'b1, 1'b0);
        en_hi = 0;
        repeat (4) begin
            @(posedge clk);
            #1 if (core_en) en_hi++;
        end
        @(negedge clk);
        bus_idle();
        @(posedge clk);
        #1 if (core_en) en_hi++;
        check("t5_core_en_during_xfer", en_hi, 0);
        @(posedge clk);
        #1 check("t5_core_en_back", core_en, 1);
        @(negedge clk);
        instruction_load_start = 1'b1;
        @(posedge clk);
        #1 check("t5_core_en_load", core_en, 0);
        @(negedge clk);
        core_select = 1'b0;

        // 6: reset during ACCESS of an imem write
        @(negedge clk);
        start_req(32'h7, 32'hABCD, 1'b1, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1 check("t6_in_access", imem_we, 1);
        check("t6_count_pre", load_count, 21);
        #2 rst = 1'b0;
        #1 check("t6_imem_we_rst", imem_we, 0);
        check("t6_count_rst", load_count, 0);
        check("t6_core_en_rst", core_en, 0);
        check("t6_state_idle", dut.state_q, ST_IDLE);
        @(negedge clk);
        bus_idle();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        xfer(32'h7, 32'hABCD, 1'b1, 1'b1, 4);
        check("t6_count_after", load_count, 1);

        // 7: load_count saturates at 2**AL
        s_imem = n_imem;
        for (int i = 0; i < 2049; i++)
            xfer(i & 32'h7FF, i, 1'b1, 1'b1, 1);
        check("t7_imem_pulses", n_imem - s_imem, 2049);
        check("t7_load_count_sat", load_count, 12'h800);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb_load_responder.md
Name: apb_load_responder

Overview:
Core-side responder for the host load/debug bus (addr_in, data_in, pselect, pwrite, pready). It turns each host transfer into exactly one instruction-memory write, data-memory write, or data-memory read, whatever the host's hold time. It also gates core execution (core_en) against core_select and instruction_load_start. It sits inside corefinal, between the host bus pins and the imem/dmem write and read ports.

Parameters:
DATA_LENGTH, 32, memory word width and data_in/data_out width.
ADDRESS_LENGTH, 11, word-address width of imem and dmem (2048 words each).

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  asynchronous active-low reset.
core_select  input  1  host request to run the core.
instruction_load_start  input  1  1 = writes target imem; 0 = writes target dmem.
addr_in  input  32  host address. Word index when loading imem; byte address for dmem.
data_in  input  DATA_LENGTH  host write data.
pselect  input  1  transfer select, held high by the host for one or more cycles.
pwrite  input  1  1 = write, 0 = read.
pready  input  1  host qualifier; a transfer starts only when pselect & pready.
data_out  output  DATA_LENGTH  read data, held until the next read completes.
xfer_done  output  1  one-cycle pulse when a transfer completes (ok or error).
xfer_err  output  1  one-cycle pulse, coincident with xfer_done, for a rejected transfer.
imem_we  output  1  imem write strobe, one cycle per accepted transfer.
imem_addr  output  ADDRESS_LENGTH  imem word address.
imem_wdata  output  DATA_LENGTH  imem write data.
dmem_we  output  1  dmem write strobe.
dmem_re  output  1  dmem read strobe.
dmem_addr  output  ADDRESS_LENGTH  dmem word address.
dmem_wdata  output  DATA_LENGTH  dmem write data.
dmem_rdata  input  DATA_LENGTH  dmem read data, valid one cycle after dmem_re.
core_en  output  1  core run enable. The core is held in reset while this is 0.
load_count  output  ADDRESS_LENGTH+1  number of accepted imem writes since the last reset.

Behaviour:
- Reset (rst=0, asynchronous): FSM to IDLE. All strobes, xfer_done, xfer_err and core_en are 0. data_out, imem_*/dmem_* address and data outputs, and load_count are all 0.
- FSM states: IDLE, CAPTURE, ACCESS, RDWAIT, RELEASE.
- IDLE:
  - Leave to CAPTURE when pselect & pready.
  - In the same edge, register addr_in, data_in, pwrite, and instruction_load_start (as target).
- CAPTURE: decode the registered transfer, then go to ACCESS.
  - Write, target imem: legal if addr[31:ADDRESS_LENGTH]==0; word index = addr[ADDRESS_LENGTH-1:0].
  - Write, target dmem: legal if addr[1:0]==0 and addr[31:ADDRESS_LENGTH+2]==0; word index = addr[ADDRESS_LENGTH+1:2].
  - Read: always dmem, same decode as dmem write.
  - A read while instruction_load_start=1 is rejected (error).
- ACCESS:
  - Legal write: the selected *_we is high for exactly this cycle. xfer_done pulses. An imem write increments load_count, saturating at 2**ADDRESS_LENGTH. Next state RELEASE.
  - Legal read: dmem_re high this cycle. Next state RDWAIT.
  - Illegal transfer: no strobe; xfer_done and xfer_err pulse. Next state RELEASE.
- RDWAIT: latch dmem_rdata into data_out and pulse xfer_done. Next state RELEASE. Read latency from pselect&pready sampled = 3 cycles to data_out valid.
- RELEASE: wait for pselect=0, then go to IDLE. A pselect held high for N cycles therefore produces exactly one access. A new transfer needs pselect low for at least one cycle.
- pready dropping after capture is ignored. Inputs are sampled only in IDLE.
- Minimum transfer spacing is 4 cycles; a 4-cycle pselect hold is sufficient.
- core_en (registered): next value = core_select & ~instruction_load_start & (state==IDLE) & ~(pselect & pready).
  - Deasserting core_select or starting a new transfer clears core_en on the next edge.
- Reset mid-transfer: the transfer is abandoned, no strobe is issued, and load_count clears.
- Simultaneous core_select=1 with a transfer request: the transfer wins and core_en stays 0 until the transfer finishes and the bus returns to IDLE.

Decomposition:
- Shared package rv32i_bus_pkg holds:
  - FSM state enum typedef load_state_t;
  - target enum {TGT_IMEM, TGT_DMEM};
  - constants IMEM_WORDS and DMEM_WORDS = 2**ADDRESS_LENGTH.
- One natural sub-module, apb_addr_decode: combinational legality and word-index decode from (addr, pwrite, target). It is instantiated once in CAPTURE.

Test Plan:
1. Reset, then write addr_in=0x5, data_in=0x00500093, load=1, pselect held 4 cycles -> exactly one imem_we pulse, imem_addr=5, imem_wdata=0x00500093, load_count=1, xfer_err=0.
2. Write 20 sequential imem words (0..19) with 4-cycle holds -> 20 imem_we pulses, load_count=20, no dmem strobes.
3. load=0, write addr_in=0x294 (660), data_in=0xDEADBEEF -> dmem_we once, dmem_addr=165. Then read 0x294 with dmem_rdata model returning 0xDEADBEEF -> data_out=0xDEADBEEF 3 cycles after select, xfer_done pulses once.
4. Write addr_in=0x802 with load=1, then a dmem write to 0x2A1 (misaligned) -> no strobes, xfer_err and xfer_done pulse once each.
5. core_select=1 with load=0, bus idle -> core_en=1 next cycle. Start a transfer -> core_en=0 until the bus returns to IDLE.
6. Assert rst=0 during ACCESS of an imem write -> imem_we=0 immediately, load_count=0, FSM IDLE, core_en=0.
